// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit add/subtract, CHUNK bits per clock, LSB chunk first.
// Latency: start accepted at a clock edge -> busy for N=WIDTH/CHUNK cycles -> done pulse in cycle N+1.
// Backpressure: none; start is ignored while busy and accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, sub      request an operation; sub=1 selects a-b (cin ignored)
//   a, b, cin       operands and carry-in, latched when start is accepted
//   busy, done      RUN indicator, one-cycle completion pulse
//   sum, cout       result and carry-out (for subtraction cout=1 means no borrow)
//   overflow        two's-complement overflow of the completed operation
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] s;
  logic             c;
  logic             msb_cin;
  logic             accept;
  logic             last;

  // One shared CHUNK-bit slice; the carry between chunks lives in carry_reg.
  always_comb begin
    {c, s} = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
           + {{CHUNK{1'b0}}, carry_reg};
  end

  // Carry into the slice's top bit, recovered from its sum bit. On the final
  // chunk that top bit is bit WIDTH-1 of the full result.
  assign msb_cin = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ s[CHUNK-1];

  // New chunk enters at the top of acc, so after N shifts the LSB chunk has
  // arrived at the bottom.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign acc_nxt = s;
    end else begin : g_multi
      assign acc_nxt = {s, acc[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub ? 1'b1 : cin;
      cnt       <= '0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      acc       <= acc_nxt;
      carry_reg <= c;
      cnt       <= cnt + CW'(1);
      if (last) begin
        sum      <= acc_nxt;
        cout     <= c;
        overflow <= msb_cin ^ c;
      end
    end
  end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Multi-cycle parametrised adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, through a registered carry chain. It trades latency for a narrow carry path, reusing one CHUNK-bit adder slice across WIDTH/CHUNK cycles. It sits in the arithmetic datapath as a start/done-handshaked functional unit for callers that can tolerate multi-cycle results.

## Interface
- WIDTH, 16: operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4: bits added per clock cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b+cin, 1 = a−b (computed as a+~b+1; cin ignored).
- a  in  WIDTH  operand A, latched on the accepting edge.
- b  in  WIDTH  operand B, latched on the accepting edge.
- cin  in  1  carry-in for addition, latched on the accepting edge.
- busy  out  1  high while chunks are being processed.
- done  out  1  single-cycle pulse when a result becomes valid.
- sum  out  WIDTH  result; holds the last completed value.
- cout  out  1  carry-out of MSB. For subtraction, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/CHUNK. States are IDLE, RUN, DONE.
- IDLE → RUN on start=1:
  - latch a into A_reg and (sub ? ~b : b) into B_reg;
  - carry_reg ← sub ? 1 : cin;
  - chunk counter ← 0.
- RUN, each cycle:
  - slice computes {c, s} = A_reg[CHUNK-1:0] + B_reg[CHUNK-1:0] + carry_reg, in CHUNK+1 bits;
  - A_reg and B_reg shift right by CHUNK;
  - s shifts into the top of the internal result register acc, which shifts right by CHUNK;
  - carry_reg ← c;
  - counter increments.
- On the last chunk (counter = N−1):
  - sum ← final acc;
  - cout ← c;
  - overflow ← (carry into bit WIDTH−1) XOR c, where carry into bit WIDTH−1 is taken from inside the slice on the final chunk;
  - state → DONE.
- DONE lasts one cycle with done=1:
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation), giving RUN next;
  - otherwise the next state is IDLE.
- start in RUN is ignored; operands may change freely after acceptance.
- sum, cout and overflow change only on the completion edge. They hold their value through IDLE and through any following RUN until the next completion.
- Reset values (immediate on rst, independent of clk): state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, all internal registers 0.
- Reset mid-RUN aborts the operation with no partial result exposed. The first start after rst deasserts behaves as a fresh operation.
- CHUNK = WIDTH is legal: N=1, one RUN cycle.

## Timing
- start high in cycle 0 (accepted at the end of cycle 0).
- busy is high in cycles 1..N, and is 0 in IDLE and DONE.
- done is high in cycle N+1 only. sum, cout and overflow are valid from cycle N+1 onward.
- Latency from start to done is N+1 cycles.
- Throughput is one result per N+1 cycles when start is held high continuously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, cin=0, sub=0, start pulsed in cycle 0 -> busy in cycles 1–4, done only in cycle 5, sum=0x5555, cout=0, overflow=0.
- Wrap-around and flags at the same parameters:
  - a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, overflow=0;
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtraction:
  - sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0;
  - sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Handshake:
  - start pulsed again in cycles 2 and 3 of an operation -> ignored, done still only in cycle 5;
  - start held high through the done cycle -> second operation accepted, busy again in cycles 6–9, second done in cycle 10;
  - sum holds the first result through cycles 6–9.
- Reset: rst asserted asynchronously mid-cycle 2 of an operation -> busy, done, sum, cout and overflow go to 0 immediately and no done follows. After deassertion, a=0x0010, b=0x0020 yields sum=0x0030 with normal latency.
- Parameter sweep: WIDTH=8, CHUNK=1 with a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, overflow=0, done in cycle 9. WIDTH=8, CHUNK=8 with the same inputs -> same result, done in cycle 2.
